// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction buffer between fetch and decode.
// Circular buffer of {pc, instr} entries with valid/ready handshakes on both
// sides. A flush (redirect) drops every buffered entry in one cycle.

module fetch_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [31:0]                in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] occ;
    logic             enq;
    logic             deq;

    // Handshake status comes from registered occupancy only, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (occ != CNT_W'(DEPTH));
    assign out_valid = (occ != '0);
    assign count     = occ;

    // Flush overrides both transfers in its cycle.
    assign enq = in_valid && in_ready && !flush;
    assign deq = out_valid && out_ready && !flush;

    // Oldest entry is presented; zeros when empty so decode sees opcode 0.
    assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;

    // Pointer and occupancy update; pointers wrap modulo DEPTH naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Entry storage; contents are never cleared, occupancy defines validity.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a queue-based reference model checked against the
// DUT after every cycle, plus hand-computed literal expectations.

module tb_fetch_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned XLEN  = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic [XLEN-1:0]  in_pc;
    logic [31:0]      in_instr;
    logic             in_ready;
    logic             out_valid;
    logic [XLEN-1:0]  out_pc;
    logic [31:0]      out_instr;
    logic             out_ready;
    logic [3:0]       count;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] m_pc[$];
    logic [31:0] m_instr[$];

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every DUT output with the model's view of the queue.
    task automatic compare_all();
        int n;
        n = m_pc.size();
        check("model_out_valid", 32'(out_valid), 32'(n != 0));
        check("model_count",     32'(count),     32'(n));
        check("model_in_ready",  32'(in_ready),  32'(n != DEPTH));
        check("model_out_pc",    out_pc,    (n != 0) ? m_pc[0]    : 32'h0);
        check("model_out_instr", out_instr, (n != 0) ? m_instr[0] : 32'h0);
    endtask

    // One clock cycle: drive inputs, advance model on the edge, compare after.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl);
        bit full;
        bit empty;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        full  = (m_pc.size() == DEPTH);
        empty = (m_pc.size() == 0);
        if (fl) begin
            m_pc.delete();
            m_instr.delete();
        end else begin
            if (ordy && !empty) begin
                void'(m_pc.pop_front());
                void'(m_instr.pop_front());
            end
            if (v && !full) begin
                m_pc.push_back(pc);
                m_instr.push_back(ins);
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && m_pc.size() != 0; k++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        check("drain_empty", 32'(count), 32'h0);
    endtask

    int pushed;
    int popped;

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_pc = 32'h4; in_instr = 32'h13;
        out_ready = 1'b0;
        #2;
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_out_instr", out_instr, 32'h0);
        check("reset_count",     32'(count), 32'h0);
        check("reset_in_ready",  32'(in_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        compare_all();

        // First enqueue from empty
        step(1'b1, 32'h0, 32'h00500093, 1'b0, 1'b0);
        check("first_out_valid", 32'(out_valid), 32'h1);
        check("first_out_instr", out_instr, 32'h00500093);
        check("first_out_pc",    out_pc, 32'h0);
        check("first_count",     32'(count), 32'h1);
        drain();

        // Fill to full with backpressure, then a rejected 9th entry
        for (int i = 0; i < 8; i++) step(1'b1, 32'(i * 4), 32'h1000 + 32'(i), 1'b0, 1'b0);
        check("full_count",    32'(count), 32'h8);
        check("full_in_ready", 32'(in_ready), 32'h0);
        step(1'b1, 32'h20, 32'hdead, 1'b0, 1'b0);
        check("ninth_rejected", 32'(count), 32'h8);
        for (int i = 0; i < 8; i++) begin
            check("drain_order_pc", out_pc, 32'(i * 4));
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        check("drained_count", 32'(count), 32'h0);

        // Full with simultaneous enqueue/dequeue
        for (int i = 0; i < 8; i++) step(1'b1, 32'h300 + 32'(i * 4), 32'h2000 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'h320, 32'h2008, 1'b1, 1'b0);
        check("full_enqdeq_count", 32'(count), 32'h7);
        step(1'b1, 32'h324, 32'h2009, 1'b1, 1'b0);
        check("enqdeq_count_hold", 32'(count), 32'h7);
        check("enqdeq_head_pc",    out_pc, 32'h308);
        drain();

        // Wrap-around streaming with toggling out_ready
        pushed = 0;
        popped = 0;
        for (int c = 0; c < 200 && popped < 20; c++) begin
            logic ordy;
            logic v;
            ordy = (c % 2 == 0);
            v = (pushed < 20);
            if (out_valid && ordy) begin
                check("wrap_order_pc", out_pc, 32'(popped * 4));
                popped++;
            end
            if (v && in_ready) begin
                step(1'b1, 32'(pushed * 4), 32'h3000 + 32'(pushed), ordy, 1'b0);
                pushed++;
            end else begin
                step(1'b0, 32'h0, 32'h0, ordy, 1'b0);
            end
        end
        check("wrap_all_popped", 32'(popped), 32'd20);
        check("wrap_empty", 32'(count), 32'h0);

        // Flush with concurrent enqueue and dequeue
        for (int i = 0; i < 5; i++) step(1'b1, 32'h500 + 32'(i * 4), 32'h4000 + 32'(i), 1'b0, 1'b0);
        check("pre_flush_count", 32'(count), 32'h5);
        step(1'b1, 32'h100, 32'h4100, 1'b1, 1'b1);
        check("flush_count",     32'(count), 32'h0);
        check("flush_out_valid", 32'(out_valid), 32'h0);
        check("flush_in_ready",  32'(in_ready), 32'h1);
        step(1'b1, 32'h200, 32'h4200, 1'b0, 1'b0);
        check("post_flush_pc",    out_pc, 32'h200);
        check("post_flush_count", 32'(count), 32'h1);
        drain();

        // Asynchronous reset between edges
        for (int i = 0; i < 4; i++) step(1'b1, 32'h600 + 32'(i * 4), 32'h5000 + 32'(i), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        m_pc.delete();
        m_instr.delete();
        check("async_out_valid", 32'(out_valid), 32'h0);
        check("async_count",     32'(count), 32'h0);
        check("async_in_ready",  32'(in_ready), 32'h1);
        check("async_out_pc",    out_pc, 32'h0);
        check("async_out_instr", out_instr, 32'h0);
        #1 reset = 1'b0;
        @(negedge clk);
        compare_all();
        step(1'b1, 32'h40, 32'h6000, 1'b0, 1'b0);
        check("after_reset_pc",    out_pc, 32'h40);
        check("after_reset_count", 32'(count), 32'h1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
